alu_issue: RTL and testbench

Upstream issue stage for the EX-stage ALU. Accepts ALU commands (ALUOp, A, B) over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It presents one command at a time from a registered output stage whose A/B/ALUOp outputs drive the ALU inputs directly, so the ALU result is valid in the same cycle as `out_valid`. It decouples a bursty operand producer from a consumer that may stall.

---
 rtl/alu_issue_if.sv | 28 ++
 rtl/alu_issue.sv | 109 ++++++++++
 tb/tb_alu_issue.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// Handshake bundle between the ALU issue stage, its operand producer and the ALU consumer.
// The slave modport is the issue stage; the master modport is the producer/consumer side.
interface alu_issue_if #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
);
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    in_op;
   logic [31:0]   in_a;
   logic [31:0]   in_b;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_A;
   logic [31:0]   out_B;
   logic [2:0]    out_ALUOp;
   logic [CW-1:0] count;

   modport master (
      output in_valid, in_op, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_A, out_B, out_ALUOp, count
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, out_ready,
      output in_ready, out_valid, out_A, out_B, out_ALUOp, count
   );
endinterface

// File: rtl/alu_issue.sv
// ALU issue stage: DEPTH-entry command FIFO feeding a registered output stage wired to the ALU.
// Optional build macro ALU_SHAMT_MASK_EN clamps stored shift amounts (ops 4/5) to B[4:0].
module alu_issue #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input logic        clk,
   input logic        reset,
   alu_issue_if.slave bus
);
   localparam int            AW   = $clog2(DEPTH);
   localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } cmd_t;

   cmd_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   fifo_cnt_reg;
   logic          out_valid_reg;
   cmd_t          out_reg;
   logic [CW-1:0] count_reg;

   cmd_t in_cmd;
   logic push;
   logic pop;
   logic load;
   logic fifo_nonempty;
   logic from_fifo;
   logic bypass;
   logic fifo_wr;

   always_comb begin
      in_cmd.op = bus.in_op;
      in_cmd.a  = bus.in_a;
      in_cmd.b  = bus.in_b;
`ifdef ALU_SHAMT_MASK_EN
      if (bus.in_op == 3'd4 || bus.in_op == 3'd5) begin
         in_cmd.b = {27'b0, bus.in_b[4:0]};
      end
`else
`endif
   end

   // Readiness depends only on FIFO occupancy, never on out_ready.
   assign bus.in_ready  = reset && (fifo_cnt_reg < FULL);

   assign push          = bus.in_valid && bus.in_ready;
   assign pop           = out_valid_reg && bus.out_ready;
   assign load          = !out_valid_reg || pop;
   assign fifo_nonempty = (fifo_cnt_reg != '0);
   assign from_fifo     = load && fifo_nonempty;
   assign bypass        = load && !fifo_nonempty && push;
   assign fifo_wr       = push && !bypass;

   // Storage has no reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (fifo_wr) begin
         mem[wr_ptr_reg] <= in_cmd;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         fifo_cnt_reg  <= '0;
         out_valid_reg <= 1'b0;
         out_reg       <= '0;
         count_reg     <= '0;
      end else begin
         if (fifo_wr) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (from_fifo) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({fifo_wr, from_fifo})
            2'b10:   fifo_cnt_reg <= fifo_cnt_reg + (AW+1)'(1);
            2'b01:   fifo_cnt_reg <= fifo_cnt_reg - (AW+1)'(1);
            default: fifo_cnt_reg <= fifo_cnt_reg;
         endcase
         // Data registers hold their last value when the stage empties.
         if (load) begin
            out_valid_reg <= fifo_nonempty || push;
            if (from_fifo) begin
               out_reg <= mem[rd_ptr_reg];
            end else if (bypass) begin
               out_reg <= in_cmd;
            end
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign bus.out_valid = out_valid_reg;
   assign bus.out_A     = out_reg.a;
   assign bus.out_B     = out_reg.b;
   assign bus.out_ALUOp = out_reg.op;
   assign bus.count     = count_reg;
endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: stimulus queues expected commands, a negedge monitor pops and checks.
// Expected B/C values follow the ALU_SHAMT_MASK_EN build when that macro is defined.
module tb_alu_issue;
   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_b;
      logic [31:0] exp_c;
   } item_t;

   logic  clk = 1'b0;
   logic  reset = 1'b1;
   int    total = 0;
   int    passed = 0;
   int    pushed = 0;
   int    popped = 0;
   item_t q[$];
   item_t cur;

   alu_issue_if #(.DEPTH(4)) bus ();

   alu_issue #(.DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a >> b;
         default: return 32'($signed(a) >>> b);
      endcase
   endfunction

   function automatic logic [31:0] shamt_b(input logic [2:0] op, input logic [31:0] b);
`ifdef ALU_SHAMT_MASK_EN
      if (op == 3'd4 || op == 3'd5) return {27'b0, b[4:0]};
`endif
      return b;
   endfunction

   function automatic item_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] eb, input logic [31:0] ec);
      item_t it;
      it.op = op; it.a = a; it.b = b; it.exp_b = eb; it.exp_c = ec;
      return it;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got === want) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
   endtask

   // Monitor: checks occupancy against the scoreboard, then pops/compares, then records an accept.
   always @(negedge clk) begin
      if (reset) begin
         chk("count", 32'(bus.count), 32'(q.size()));
         chk("count_max", 32'(bus.count <= 3'd5), 32'd1);
         chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
         chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 5));
         if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
               chk("sb_nonempty", 32'd0, 32'd1);
            end else begin
               item_t e;
               e = q.pop_front();
               chk("out_ALUOp", 32'(bus.out_ALUOp), 32'(e.op));
               chk("out_A", bus.out_A, e.a);
               chk("out_B", bus.out_B, e.exp_b);
               chk("alu_c", alu_f(bus.out_ALUOp, bus.out_A, bus.out_B), e.exp_c);
               popped++;
               $display("pop  op=%0d A=%h B=%h", bus.out_ALUOp, bus.out_A, bus.out_B);
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            q.push_back(cur);
            pushed++;
            $display("push op=%0d a=%h b=%h", cur.op, cur.a, cur.b);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input item_t it);
      cur          = it;
      bus.in_op    = it.op;
      bus.in_a     = it.a;
      bus.in_b     = it.b;
      bus.in_valid = 1'b1;
   endtask

   task automatic wait_accept();
      bit got = 1'b0;
      int n = 0;
      while (!got && n < 200) begin
         @(negedge clk);
         got = bus.in_ready;
         cyc();
         n++;
      end
      if (!got) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic send(input item_t it);
      offer(it);
      wait_accept();
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (bus.count != 0 && n < 100) begin
         cyc();
         n++;
      end
      chk("drain_count", 32'(bus.count), 32'd0);
      chk("drain_sb", 32'(q.size()), 32'd0);
   endtask

   function automatic item_t rand_item();
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] eb;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
      eb = shamt_b(op, b);
      return mk(op, a, b, eb, alu_f(op, a, eb));
   endfunction

   item_t dir_vec[9];

   initial begin
      int acc;
      int cycles;
      bit pend;

      bus.in_valid  = 1'b0;
      bus.in_op     = '0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b0;
      cur           = mk(0, 0, 0, 0, 0);

      dir_vec[0] = mk(3'd0, 32'd5, 32'd7, 32'd7, 32'd12);
      dir_vec[1] = mk(3'd1, 32'd3, 32'd5, 32'd5, 32'hFFFF_FFFE);
      dir_vec[2] = mk(3'd2, 32'hF0F0_FFFF, 32'h0FF0_00FF, 32'h0FF0_00FF, 32'h00F0_00FF);
      dir_vec[3] = mk(3'd3, 32'hF000_0000, 32'h0000_000F, 32'h0000_000F, 32'hF000_000F);
`ifdef ALU_SHAMT_MASK_EN
      dir_vec[4] = mk(3'd4, 32'h8000_0000, 32'h21, 32'h1, 32'h4000_0000);
      dir_vec[5] = mk(3'd5, 32'h8000_0000, 32'h24, 32'h4, 32'hF800_0000);
`else
      dir_vec[4] = mk(3'd4, 32'h8000_0000, 32'h21, 32'h21, 32'h0);
      dir_vec[5] = mk(3'd5, 32'h8000_0000, 32'h24, 32'h24, 32'hFFFF_FFFF);
`endif
      dir_vec[6] = mk(3'd7, 32'h8000_0000, 32'h3, 32'h3, 32'hF000_0000);
      dir_vec[7] = mk(3'd0, 32'd1, 32'h21, 32'h21, 32'h22);
      dir_vec[8] = mk(3'd4, 32'h8000_0000, 32'h1F, 32'h1F, 32'h1);

      // Reset state
      #2 reset = 1'b0;
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_A", bus.out_A, 32'd0);
      chk("rst_out_B", bus.out_B, 32'd0);
      chk("rst_out_ALUOp", 32'(bus.out_ALUOp), 32'd0);
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      #20 reset = 1'b1;

      // Single command, one-edge latency
      bus.out_ready = 1'b1;
      cyc();
      send(dir_vec[0]);
      chk("lat_out_valid", 32'(bus.out_valid), 32'd1);
      chk("lat_count", 32'(bus.count), 32'd1);
      cyc();
      chk("lat_count_after", 32'(bus.count), 32'd0);

      // Fill to DEPTH+1 with a stalled consumer
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(mk(3'd0, 32'(i + 1), 32'd100, 32'd100, 32'(i + 101)));
      chk("full_count", 32'(bus.count), 32'd5);
      chk("full_in_ready", 32'(bus.in_ready), 32'd0);
      offer(mk(3'd1, 32'd50, 32'd8, 32'd8, 32'd42));
      repeat (3) cyc();
      chk("full_refuse_count", 32'(bus.count), 32'd5);
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("full_pop_in_ready", 32'(bus.in_ready), 32'd0);
      wait_accept();
      bus.in_valid = 1'b0;
      chk("push_pop_count", 32'(bus.count), 32'd4);
      drain();

      // Directed op vectors at full throughput
      bus.out_ready = 1'b1;
      for (int i = 0; i < 9; i++) send(dir_vec[i]);
      drain();

      // Reset in the middle of a burst
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(mk(3'd3, 32'(i), 32'h100, 32'h100, 32'(i) | 32'h100));
      chk("mid_count", 32'(bus.count), 32'd3);
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_out_A", bus.out_A, 32'd0);
      chk("mid_rst_out_B", bus.out_B, 32'd0);
      chk("mid_rst_out_ALUOp", 32'(bus.out_ALUOp), 32'd0);
      chk("mid_rst_count", 32'(bus.count), 32'd0);
      chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
      q.delete();
      repeat (2) cyc();
      reset = 1'b1;
      bus.out_ready = 1'b1;
      send(mk(3'd2, 32'hFF, 32'h0F, 32'h0F, 32'h0F));
      drain();

      // Random valid/ready traffic
      acc = 0;
      cycles = 0;
      pend = 1'b0;
      while (acc < 1000 && cycles < 20000) begin
         cyc();
         cycles++;
         if (pend) begin
            bus.in_valid = 1'b0;
            pend = 1'b0;
            acc++;
         end
         bus.out_ready = ($urandom_range(0, 1) == 1);
         if (!bus.in_valid && acc < 1000 && $urandom_range(0, 3) != 0) offer(rand_item());
         @(negedge clk);
         if (bus.in_valid && bus.in_ready) pend = 1'b1;
      end
      bus.in_valid = 1'b0;
      chk("rand_accepted", 32'(acc), 32'd1000);
      bus.out_ready = 1'b1;
      drain();
      chk("push_pop_balance", 32'(popped), 32'(pushed - 3));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
